micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Sequences the control-unit microcode ROM: owns the micro-program counter, drives the 5-bit ROM address, and forwards the 32-bit control field to the datapath. It dispatches opcodes to their first microinstruction, resolves the JMPNZ branch on the zero flag, and stalls on memory microinstructions until memory acknowledges. Sits between the instruction register/ALU flags and the ROM inside each core's control unit.

## Interface
- UADDR_W, 5, micro-address width
- CS_W, 37, ROM word width (control field [36:5], next-address field [4:0])
- TIMEOUT_CYC, 16, memory-wait limit (used only with timeout feature)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution from FETCH1 (pulse, honoured in IDLE only)
- opcode  in  5  instruction-register opcode, sampled at FETCH2
- z_flag  in  1  ALU zero flag, sampled at FETCH2
- mem_ready  in  1  memory acknowledge for read/write microinstructions
- cs  in  37  ROM output for uaddr
- uaddr  out  5  ROM address (registered micro-PC)
- ctrl  out  32  control field to datapath
- busy  out  1  high in RUN or WAIT
- done  out  1  high in HALT
- err  out  1  sticky; illegal opcode or memory timeout

## Operation
- States: IDLE, RUN, WAIT, HALT.
- IDLE: uaddr=0, ctrl=0; start -> RUN with uaddr=0 (FETCH1).
- RUN: ctrl=cs[36:5]. Next address: if uaddr==1 (FETCH2) -> dispatch; else cs[4:0].
- Dispatch map (opcode -> uaddr): 0 RSTALL->2, 1 CONST->3, 2 MOV->4, 3 SIZE->5, 4 JMPNZ->10 if z_flag==0 else 13, 5 MOV02->14, 6 MOV13->15, 7 ADDX->16, 8 ADDY->17, 9 ADD->18, 10 SUB->19, 11 MUL->20, 12 LOAD->21, 13 STORE->24, 14 INCI->27, 15 RSTI->28, 31 END -> HALT (uaddr held at 1), all others -> HALT with err=1.
- Memory stall: cs[33] (mem read) or cs[32] (mem write) set with mem_ready=0 -> WAIT, uaddr held, ctrl held at cs[36:5]. WAIT exits to RUN, advancing normally, on the first cycle mem_ready=1. mem_ready=1 in the same cycle as the memory microinstruction -> no stall.
- Next-address fields 29–31 are illegal: HALT, err=1.
- HALT: ctrl=0, done=1; only rst leaves HALT. start in HALT is ignored.
- rst mid-operation (any state): next edge IDLE, uaddr=0, ctrl=0, busy=0, done=0, err=0.

## Timing
- One microinstruction per cycle in RUN; ROM is combinational, ctrl is combinational from cs (same cycle as uaddr).
- start -> uaddr=0 and busy=1 on the following edge; FETCH2 one cycle later.
- Dispatch: opcode/z_flag sampled in the FETCH2 cycle, target uaddr valid next cycle.
- Memory microinstruction with k cycles of mem_ready=0 occupies k+1 cycles.
- Reset values: uaddr=0, ctrl=0, busy=0, done=0, err=0, state IDLE.

## Configuration
- USEQ_MEM_TIMEOUT_EN defined: WAIT counter increments each stalled cycle; reaching TIMEOUT_CYC -> HALT, err=1, ctrl=0. Counter clears on entry to WAIT.
- Undefined: WAIT unbounded; TIMEOUT_CYC ignored, no counter logic.

## Structure
- Package useq_pkg: state enum, opcode constants (OP_RSTALL..OP_RSTI, OP_END), micro-address constants (UA_FETCH1=0, UA_FETCH2=1, UA_JMPNZY=10, UA_JMPNZN=13, ...), control-bit indices CS_MEM_RD=33, CS_MEM_WR=32.
- Sub-module useq_dispatch: combinational opcode+z_flag -> {target, halt, illegal}.

## Test plan
- Reset then start; opcode=9 (ADD) -> uaddr sequence 0,1,18,0; ctrl=0x030074 (cs[36:5] of ADD1) in the cycle uaddr=18.
- opcode=4, z_flag=0 -> uaddr 1->10->11->12->0; z_flag=1 -> 1->13->0.
- opcode=12 (LOAD), mem_ready low 3 cycles at uaddr=22 -> uaddr held 4 cycles, busy=1, then 23, 0.
- opcode=20 -> HALT, err=1, done=1, ctrl=0; start ignored; rst clears all outputs.
- opcode=31 -> done=1, err=0, uaddr held at 1.
- With USEQ_MEM_TIMEOUT_EN, TIMEOUT_CYC=16, STORE with mem_ready stuck low -> HALT, err=1 after 16 stalled cycles; without macro, still WAIT at cycle 100.

Source files
------------

// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : useq_pkg
// Description : Shared definitions for the micro-sequencer. Holds the
//               sequencer state encoding, the opcode values, the
//               micro-addresses of every routine's first microinstruction
//               and the control-word bit positions of the memory strobes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package useq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_HALT = 2'd3;

  localparam logic [4:0] OP_RSTALL = 5'd0;
  localparam logic [4:0] OP_CONST  = 5'd1;
  localparam logic [4:0] OP_MOV    = 5'd2;
  localparam logic [4:0] OP_SIZE   = 5'd3;
  localparam logic [4:0] OP_JMPNZ  = 5'd4;
  localparam logic [4:0] OP_MOV02  = 5'd5;
  localparam logic [4:0] OP_MOV13  = 5'd6;
  localparam logic [4:0] OP_ADDX   = 5'd7;
  localparam logic [4:0] OP_ADDY   = 5'd8;
  localparam logic [4:0] OP_ADD    = 5'd9;
  localparam logic [4:0] OP_SUB    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_LOAD   = 5'd12;
  localparam logic [4:0] OP_STORE  = 5'd13;
  localparam logic [4:0] OP_INCI   = 5'd14;
  localparam logic [4:0] OP_RSTI   = 5'd15;
  localparam logic [4:0] OP_END    = 5'd31;

  localparam logic [4:0] UA_FETCH1     = 5'd0;
  localparam logic [4:0] UA_FETCH2     = 5'd1;
  localparam logic [4:0] UA_RSTALL     = 5'd2;
  localparam logic [4:0] UA_CONST      = 5'd3;
  localparam logic [4:0] UA_MOV        = 5'd4;
  localparam logic [4:0] UA_SIZE       = 5'd5;
  localparam logic [4:0] UA_JMPNZY     = 5'd10;
  localparam logic [4:0] UA_JMPNZN     = 5'd13;
  localparam logic [4:0] UA_MOV02      = 5'd14;
  localparam logic [4:0] UA_MOV13      = 5'd15;
  localparam logic [4:0] UA_ADDX       = 5'd16;
  localparam logic [4:0] UA_ADDY       = 5'd17;
  localparam logic [4:0] UA_ADD1       = 5'd18;
  localparam logic [4:0] UA_SUB1       = 5'd19;
  localparam logic [4:0] UA_MUL1       = 5'd20;
  localparam logic [4:0] UA_LOAD1      = 5'd21;
  localparam logic [4:0] UA_STORE1     = 5'd24;
  localparam logic [4:0] UA_INCI       = 5'd27;
  localparam logic [4:0] UA_RSTI       = 5'd28;
  // Next-address fields above this value do not name a microinstruction.
  localparam logic [4:0] UA_LAST_LEGAL = 5'd28;

  localparam int CS_MEM_RD = 33;
  localparam int CS_MEM_WR = 32;

endpackage
`default_nettype wire

// File: rtl/useq_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : useq_dispatch
// Description : Opcode dispatch table. Maps the instruction-register opcode
//               (and the zero flag, for JMPNZ) to the first microinstruction
//               of its routine, or flags a halt.
// Ports       : opcode_i  [4:0] opcode from the instruction register
//               z_flag_i        ALU zero flag
//               target_o  [4:0] first micro-address of the routine
//               halt_o          opcode stops the sequencer
//               illegal_o       opcode is not defined (implies halt_o)
// Revision    : 1.0 - initial release
// ============================================================================
module useq_dispatch
  import useq_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic       z_flag_i,
  output logic [4:0] target_o,
  output logic       halt_o,
  output logic       illegal_o
);

  always_comb begin
    target_o  = UA_FETCH2;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RSTALL: target_o = UA_RSTALL;
      OP_CONST:  target_o = UA_CONST;
      OP_MOV:    target_o = UA_MOV;
      OP_SIZE:   target_o = UA_SIZE;
      // Jump taken when the last result was non-zero.
      OP_JMPNZ:  target_o = z_flag_i ? UA_JMPNZN : UA_JMPNZY;
      OP_MOV02:  target_o = UA_MOV02;
      OP_MOV13:  target_o = UA_MOV13;
      OP_ADDX:   target_o = UA_ADDX;
      OP_ADDY:   target_o = UA_ADDY;
      OP_ADD:    target_o = UA_ADD1;
      OP_SUB:    target_o = UA_SUB1;
      OP_MUL:    target_o = UA_MUL1;
      OP_LOAD:   target_o = UA_LOAD1;
      OP_STORE:  target_o = UA_STORE1;
      OP_INCI:   target_o = UA_INCI;
      OP_RSTI:   target_o = UA_RSTI;
      OP_END:    halt_o   = 1'b1;
      default: begin
        halt_o    = 1'b1;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Microcode sequencer. Owns the micro-PC that addresses the
//               combinational control ROM, forwards the ROM control field to
//               the datapath, dispatches opcodes at FETCH2 and stalls on
//               memory microinstructions until mem_ready.
// Ports       : clk, rst          clock, synchronous active-high reset
//               start             begin at FETCH1 (honoured in IDLE only)
//               opcode, z_flag    dispatch inputs, sampled at FETCH2
//               mem_ready         memory acknowledge
//               cs                ROM word {control[36:5], next[4:0]}
//               uaddr             ROM address (registered micro-PC)
//               ctrl              control field to datapath
//               busy / done / err RUN-or-WAIT / HALT / sticky error
// Options     : USEQ_MEM_TIMEOUT_EN - bound WAIT to TIMEOUT_CYC stalled
//               cycles, then halt with err.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int UADDR_W     = 5,
  parameter int CS_W        = 37,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              opcode,
  input  logic                    z_flag,
  input  logic                    mem_ready,
  input  logic [CS_W-1:0]         cs,
  output logic [UADDR_W-1:0]      uaddr,
  output logic [CS_W-UADDR_W-1:0] ctrl,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  state_t               state_q, state_d;
  logic [UADDR_W-1:0]   uaddr_q, uaddr_d;
  logic                 err_q, err_d;

  logic [4:0]           disp_target;
  logic                 disp_halt;
  logic                 disp_illegal;

  // Outcome of completing the current microinstruction.
  state_t               adv_state;
  logic [UADDR_W-1:0]   adv_uaddr;
  logic                 adv_err;

  logic                 mem_op;
  logic [UADDR_W-1:0]   next_field;

  assign mem_op     = cs[CS_MEM_RD] | cs[CS_MEM_WR];
  assign next_field = cs[UADDR_W-1:0];

  useq_dispatch u_dispatch (
    .opcode_i  (opcode),
    .z_flag_i  (z_flag),
    .target_o  (disp_target),
    .halt_o    (disp_halt),
    .illegal_o (disp_illegal)
  );

  // Halting keeps the micro-PC on the microinstruction that caused it.
  always_comb begin
    adv_state = ST_RUN;
    adv_uaddr = next_field;
    adv_err   = 1'b0;
    if (uaddr_q == UA_FETCH2) begin
      if (disp_halt) begin
        adv_state = ST_HALT;
        adv_uaddr = uaddr_q;
        adv_err   = disp_illegal;
      end else begin
        adv_uaddr = disp_target;
      end
    end else if (next_field > UA_LAST_LEGAL) begin
      adv_state = ST_HALT;
      adv_uaddr = uaddr_q;
      adv_err   = 1'b1;
    end
  end

`ifdef USEQ_MEM_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic cfg_unused;
  assign cfg_unused = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d = state_q;
    uaddr_d = uaddr_q;
    err_d   = err_q;
`ifdef USEQ_MEM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        uaddr_d = UA_FETCH1;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_op && !mem_ready) begin
          state_d = ST_WAIT;
`ifdef USEQ_MEM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          state_d = adv_state;
          uaddr_d = adv_uaddr;
          err_d   = err_q | adv_err;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = adv_state;
          uaddr_d = adv_uaddr;
          err_d   = err_q | adv_err;
        end
`ifdef USEQ_MEM_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      uaddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      err_q   <= err_d;
    end
  end

`ifdef USEQ_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign uaddr = uaddr_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign done  = (state_q == ST_HALT);
  assign err   = err_q;
  // The ROM is addressed by the registered micro-PC, so in WAIT this is the
  // stalled microinstruction's control field.
  assign ctrl  = busy ? cs[CS_W-1:UADDR_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer. A behavioural ROM
//               image drives cs; each instruction's expected micro-address
//               trace is built from the opcode's routine and walked cycle by
//               cycle, with randomized opcodes, flags and memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic        z_flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic [36:0] cs;
  logic [4:0]  uaddr;
  logic [31:0] ctrl;
  logic        busy, done, err;

  logic [36:0] rom [0:31];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cs = rom[uaddr];

  micro_sequencer #(.UADDR_W(5), .CS_W(37), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .z_flag(z_flag),
    .mem_ready(mem_ready), .cs(cs), .uaddr(uaddr), .ctrl(ctrl),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_of(input int a);
    logic [36:0] w;
    w = rom[a];
    return w[36:5];
  endfunction

  function automatic bit is_mem(input int a);
    return (a == 22) || (a == 25);
  endfunction

  function automatic logic [4:0] next_of(input int a);
    case (a)
      0:  return 5'd1;
      10: return 5'd11;
      11: return 5'd12;
      21: return 5'd22;
      22: return 5'd23;
      24: return 5'd25;
      25: return 5'd26;
      28: return 5'd30;   // illegal next-address field
      default: return 5'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input int a, input bit b, input bit d,
                              input bit e, input logic [31:0] c);
    @(negedge clk);
    check({tag, "_uaddr"}, uaddr, a);
    check({tag, "_ctrl"}, ctrl, c);
    check({tag, "_flags"}, {busy, done, err}, {b, d, e});
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("reset", {uaddr, ctrl, busy, done, err}, 64'd0);
    tick();
    rst = 1'b0;
  endtask

  // kind: 0 returns to FETCH1, 1 clean halt, 2 error halt
  task automatic run_trial(input logic [4:0] op, input logic z, input int k);
    int path[$];
    int kind;
    do_reset();
    opcode = op; z_flag = z; start = 1'b1;
    expect_cycle("idle", 0, 0, 0, 0, 32'd0);
    start = 1'b0;
    path = {0, 1};
    kind = 0;
    case (op)
      0:  path.push_back(2);
      1:  path.push_back(3);
      2:  path.push_back(4);
      3:  path.push_back(5);
      4:  if (!z) begin path.push_back(10); path.push_back(11); path.push_back(12); end
          else path.push_back(13);
      5:  path.push_back(14);
      6:  path.push_back(15);
      7:  path.push_back(16);
      8:  path.push_back(17);
      9:  path.push_back(18);
      10: path.push_back(19);
      11: path.push_back(20);
      12: begin path.push_back(21); path.push_back(22); path.push_back(23); end
      13: begin path.push_back(24); path.push_back(25); path.push_back(26); end
      14: path.push_back(27);
      15: begin path.push_back(28); kind = 2; end
      31: kind = 1;
      default: kind = 2;
    endcase
    if (kind == 0) path.push_back(0);
    foreach (path[i]) begin
      int hold;
      hold = is_mem(path[i]) ? k : 0;
      for (int s = 0; s <= hold; s++) begin
        if (is_mem(path[i])) mem_ready = (s < hold) ? 1'b0 : 1'b1;
        else                 mem_ready = 1'($urandom_range(0, 1));
        expect_cycle("run", path[i], 1, 0, 0, ctrl_of(path[i]));
      end
    end
    if (kind != 0) begin
      for (int s = 0; s < 3; s++) begin
        start = (s == 1);
        mem_ready = 1'($urandom_range(0, 1));
        expect_cycle("halt", path[$], 0, 1, kind == 2, 32'd0);
      end
    end
    start = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin
      logic [31:0] c;
      c = $urandom() & ~32'h1800_0000;
      if (a == 22) c = c | 32'h1000_0000;
      if (a == 25) c = c | 32'h0800_0000;
      if (a == 18) c = 32'h0003_0074;
      rom[a] = {c, (a == 1) ? 5'($urandom_range(0, 31)) : next_of(a)};
    end

    // Directed cases
    run_trial(5'd9,  1'b0, 0);   // ADD: 0,1,18,0
    run_trial(5'd4,  1'b0, 0);   // JMPNZ taken
    run_trial(5'd4,  1'b1, 0);   // JMPNZ not taken
    run_trial(5'd12, 1'b0, 3);   // LOAD, 3 stall cycles
    run_trial(5'd13, 1'b1, 0);   // STORE, no stall
    run_trial(5'd20, 1'b0, 0);   // illegal opcode
    run_trial(5'd31, 1'b0, 0);   // END
    run_trial(5'd15, 1'b0, 0);   // RSTI hits illegal next field

    // Reset in the middle of a stalled LOAD
    do_reset();
    opcode = 5'd12; start = 1'b1;
    tick();
    start = 1'b0; mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    expect_cycle("mid", 22, 1, 0, 0, ctrl_of(22));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid", {uaddr, ctrl, busy, done, err}, 64'd0);
    tick();
    rst = 1'b0; mem_ready = 1'b1;

    // STORE with memory stuck low
    do_reset();
    opcode = 5'd13; start = 1'b1;
    expect_cycle("to_idle", 0, 0, 0, 0, 32'd0);
    start = 1'b0;
    expect_cycle("to_run", 0, 1, 0, 0, ctrl_of(0));
    expect_cycle("to_run", 1, 1, 0, 0, ctrl_of(1));
    expect_cycle("to_run", 24, 1, 0, 0, ctrl_of(24));
    mem_ready = 1'b0;
`ifdef USEQ_MEM_TIMEOUT_EN
    begin
      int  cyc;
      bit  seen;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        if (done) seen = 1;
        else begin cyc++; tick(); end
      end
      check("to_halt_seen", seen, 1);
      check("to_len_ok", (cyc >= 16) && (cyc <= 18), 1);
      check("to_halt_state", {uaddr, ctrl, busy, done, err}, {5'd25, 32'd0, 3'b011});
      tick();
    end
`else
    for (int s = 0; s < 100; s++) expect_cycle("to_wait", 25, 1, 0, 0, ctrl_of(25));
    mem_ready = 1'b1;
    expect_cycle("to_rel", 25, 1, 0, 0, ctrl_of(25));
    expect_cycle("to_rel", 26, 1, 0, 0, ctrl_of(26));
    expect_cycle("to_rel", 0, 1, 0, 0, ctrl_of(0));
`endif
    mem_ready = 1'b1;

    // Randomized instructions
    for (int t = 0; t < 40; t++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      run_trial(op, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
